mem_wr_ctrl: RTL and testbench

//   Write-side control for the systolic array output memory. Fires on the wr_active rising

---
 rtl/mem_wr_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_wr_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_ctrl.sv
// Write-side control for the systolic array output memory: skewed per-column write-enable wave and addresses.
// Optional completed-sweep counter is built only when WR_CTRL_SWEEP_CNT_EN is defined.
module mem_wr_ctrl #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               active,
    input  logic [ADDR_WIDTH-1:0]              wr_base,
    output logic [WIDTH_HEIGHT-1:0]            wr_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr,
    output logic                               busy,
    output logic                               done,
    output logic                               overrun,
    output logic [15:0]                        sweep_cnt
);

    localparam int CNT_W = $clog2(2 * WIDTH_HEIGHT);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(2 * WIDTH_HEIGHT - 2);

    typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t                             state_r, state_s;
    logic [CNT_W-1:0]                   cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0]              base_r, base_s;
    logic                               active_q_r;
    logic                               armed_r;
    logic                               start_s;
    logic                               emit_s;
    logic                               done_s;
    logic                               overrun_s;
    int                                 wave_k_s;
    logic [WIDTH_HEIGHT-1:0]            wave_en_s;
    logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wave_addr_s;

    // armed_r blocks a start until active has been seen low after reset,
    // so an active level held through reset does not look like a new edge.
    assign start_s  = active & ~active_q_r & armed_r;
    assign wave_k_s = int'(cnt_s);

    // Edge-detect history and post-reset arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q_r <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            active_q_r <= active;
            armed_r    <= armed_r | ~active;
        end
    end

    // Next-state logic: cnt holds the wave step k being presented on the outputs.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        base_s    = base_r;
        emit_s    = 1'b0;
        done_s    = 1'b0;
        overrun_s = overrun;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = SWEEP;
                    cnt_s   = {CNT_W{1'b0}};
                    base_s  = wr_base;
                    emit_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                if (start_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun;
                end
                if (cnt_r == LAST_K) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    emit_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Wave for step k: column c writes row k-c while 0 <= k-c < WIDTH_HEIGHT.
    always_comb begin
        wave_en_s   = {WIDTH_HEIGHT{1'b0}};
        wave_addr_s = {(WIDTH_HEIGHT*ADDR_WIDTH){1'b0}};
        for (int c = 0; c < WIDTH_HEIGHT; c++) begin
            if ((wave_k_s >= c) && (wave_k_s < c + WIDTH_HEIGHT)) begin
                wave_en_s[c] = 1'b1;
                wave_addr_s[c*ADDR_WIDTH +: ADDR_WIDTH] = base_s + ADDR_WIDTH'(wave_k_s - c);
            end else begin
                wave_en_s[c] = 1'b0;
                wave_addr_s[c*ADDR_WIDTH +: ADDR_WIDTH] = {ADDR_WIDTH{1'b0}};
            end
        end
    end

    // FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            base_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            base_r  <= base_s;
        end
    end

    // Registered outputs; disabled columns drive address zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= {WIDTH_HEIGHT{1'b0}};
            wr_addr <= {(WIDTH_HEIGHT*ADDR_WIDTH){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            wr_en   <= emit_s ? wave_en_s : {WIDTH_HEIGHT{1'b0}};
            wr_addr <= emit_s ? wave_addr_s : {(WIDTH_HEIGHT*ADDR_WIDTH){1'b0}};
            busy    <= emit_s;
            done    <= done_s;
            overrun <= overrun_s;
        end
    end

`ifdef WR_CTRL_SWEEP_CNT_EN
    // Completed-sweep counter, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_cnt <= 16'h0000;
        end else if (done_s) begin
            sweep_cnt <= sweep_cnt + 16'h0001;
        end else begin
            sweep_cnt <= sweep_cnt;
        end
    end
`else
    assign sweep_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Directed bench for mem_wr_ctrl with a per-cycle expected-output queue.
module tb_mem_wr_ctrl;

    localparam int W  = 16;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              active;
    logic [AW-1:0]     wr_base;
    logic [W-1:0]      wr_en;
    logic [W*AW-1:0]   wr_addr;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [15:0]       sweep_cnt;

    typedef struct {
        logic [W-1:0]    en;
        logic [W*AW-1:0] addr;
        logic            busy;
        logic            done;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_sweeps = 16'h0000;

    mem_wr_ctrl #(.WIDTH_HEIGHT(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .active(active), .wr_base(wr_base),
        .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
        .overrun(overrun), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected outputs for cycles T1..T(2W) of a sweep started with this base.
    task automatic push_sweep(input logic [AW-1:0] base);
        exp_t e;
        int   k;
        for (int j = 1; j <= 2 * W; j++) begin
            e.en   = '0;
            e.addr = '0;
            e.busy = (j < 2 * W);
            e.done = (j == 2 * W);
            k = j - 1;
            if (j < 2 * W) begin
                for (int c = 0; c < W; c++) begin
                    if (c <= k && k < c + W) begin
                        e.en[c] = 1'b1;
                        e.addr[c*AW +: AW] = base + AW'(k - c);
                    end
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then compare outputs against the queue head (idle when empty).
    task automatic step();
        exp_t        e;
        logic [15:0] exp_cnt;
        tick();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.en = '0; e.addr = '0; e.busy = 1'b0; e.done = 1'b0;
        end
        if (e.done) exp_sweeps = exp_sweeps + 16'h0001;
`ifdef WR_CTRL_SWEEP_CNT_EN
        exp_cnt = exp_sweeps;
`else
        exp_cnt = 16'h0000;
`endif
        chk("wr_en", 128'(wr_en), 128'(e.en));
        chk("wr_addr", 128'(wr_addr), 128'(e.addr));
        chk("busy", 128'(busy), 128'(e.busy));
        chk("done", 128'(done), 128'(e.done));
        chk("sweep_cnt", 128'(sweep_cnt), 128'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1; active = 1'b0; wr_base = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_wr_en", 128'(wr_en), 128'h0);
        chk("rst_wr_addr", 128'(wr_addr), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        chk("rst_overrun", 128'(overrun), 128'h0);
        chk("rst_sweep_cnt", 128'(sweep_cnt), 128'h0);
        step(); step();

        // Basic sweep at base 0x20; base change mid-sweep must not matter.
        active = 1'b1; wr_base = 8'h20;
        push_sweep(8'h20);
        for (int j = 1; j <= 34; j++) begin
            step();
            if (j == 1) begin
                active = 1'b0;
                chk("t1_en", 128'(wr_en), 128'h0001);
                chk("t1_col0", 128'(wr_addr[7:0]), 128'h20);
            end
            if (j == 5) wr_base = 8'h55;
            if (j == 16) begin
                chk("t16_en", 128'(wr_en), 128'hFFFF);
                chk("t16_col0", 128'(wr_addr[7:0]), 128'h2F);
                chk("t16_col15", 128'(wr_addr[127:120]), 128'h20);
            end
            if (j == 31) begin
                chk("t31_en", 128'(wr_en), 128'h8000);
                chk("t31_col15", 128'(wr_addr[127:120]), 128'h2F);
            end
            if (j == 32) begin
                chk("t32_done", 128'(done), 128'h1);
                chk("t32_busy", 128'(busy), 128'h0);
            end
        end

        // Level-high active: one sweep only, no overrun.
        active = 1'b1; wr_base = 8'h30;
        push_sweep(8'h30);
        for (int j = 1; j <= 40; j++) step();
        active = 1'b0;
        step(); step();
        chk("level_overrun", 128'(overrun), 128'h0);

        // Second edge at T10: sweep unchanged, overrun sticky from T11.
        active = 1'b1; wr_base = 8'h40;
        push_sweep(8'h40);
        for (int j = 1; j <= 34; j++) begin
            step();
            if (j == 1) active = 1'b0;
            if (j == 9) chk("pre_overrun", 128'(overrun), 128'h0);
            if (j == 10) active = 1'b1;
            if (j == 11) begin
                chk("t11_overrun", 128'(overrun), 128'h1);
                active = 1'b0;
            end
        end
        chk("sticky_overrun", 128'(overrun), 128'h1);

        // Reset at T12 with active held high: cleared outputs, no restart.
        active = 1'b1; wr_base = 8'h60;
        push_sweep(8'h60);
        for (int j = 1; j <= 12; j++) step();
        reset = 1'b1;
        exp_q.delete();
        exp_sweeps = 16'h0000;
        step();
        chk("t13_overrun", 128'(overrun), 128'h0);
        reset = 1'b0;
        for (int j = 0; j < 40; j++) step();
        active = 1'b0;
        step(); step();

        // Address wrap at base 0xF8.
        active = 1'b1; wr_base = 8'hF8;
        push_sweep(8'hF8);
        for (int j = 1; j <= 33; j++) begin
            step();
            if (j == 1) active = 1'b0;
            if (j == 8) chk("wrap_col0_ff", 128'(wr_addr[7:0]), 128'hFF);
            if (j == 9) chk("wrap_col0_00", 128'(wr_addr[7:0]), 128'h00);
            if (j == 16) chk("wrap_col0_07", 128'(wr_addr[7:0]), 128'h07);
        end
        chk("wrap_overrun", 128'(overrun), 128'h0);

        // Back-to-back: start edge in the done cycle.
        reset = 1'b1;
        exp_q.delete();
        exp_sweeps = 16'h0000;
        step();
        reset = 1'b0;
        step(); step();
        active = 1'b1; wr_base = 8'h10;
        push_sweep(8'h10);
        for (int j = 1; j <= 32; j++) begin
            step();
            if (j == 1) active = 1'b0;
        end
        active = 1'b1; wr_base = 8'h90;
        push_sweep(8'h90);
        for (int j = 1; j <= 34; j++) begin
            step();
            if (j == 1) begin
                active = 1'b0;
                chk("b2b_t33_en", 128'(wr_en), 128'h0001);
                chk("b2b_t33_col0", 128'(wr_addr[7:0]), 128'h90);
            end
        end
`ifdef WR_CTRL_SWEEP_CNT_EN
        chk("b2b_sweep_cnt", 128'(sweep_cnt), 128'h2);
`else
        chk("b2b_sweep_cnt", 128'(sweep_cnt), 128'h0);
`endif
        chk("b2b_overrun", 128'(overrun), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
